// File: rtl/gru_gate_feeder_if.sv
// Bus bundle between gru_gate_feeder (slave side) and the controller, weight
// store and GRU cell around it (master side).
interface gru_gate_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int HID        = 8
);
   localparam int AW = $clog2(HID);

   logic                    start;
   logic                    clear_h;
   logic                    x_wr_en;
   logic [AW-1:0]           x_wr_addr;
   logic [DATA_WIDTH-1:0]   x_wr_data;
   logic [2*AW-1:0]         w_addr;
   logic [3*DATA_WIDTH-1:0] w_ih_rdata;
   logic [3*DATA_WIDTH-1:0] w_hh_rdata;
   logic [DATA_WIDTH-1:0]   data_ir;
   logic [DATA_WIDTH-1:0]   data_iz;
   logic [DATA_WIDTH-1:0]   data_in;
   logic [DATA_WIDTH-1:0]   data_hr;
   logic [DATA_WIDTH-1:0]   data_hz;
   logic [DATA_WIDTH-1:0]   data_hn;
   logic [DATA_WIDTH-1:0]   data_hidden_in;
   logic [DATA_WIDTH-1:0]   data_hidden_out;
   logic                    busy;
   logic                    done;
   logic [AW-1:0]           h_rd_addr;
   logic [DATA_WIDTH-1:0]   h_rd_data;

   modport master (
      output start, clear_h, x_wr_en, x_wr_addr, x_wr_data,
      output w_ih_rdata, w_hh_rdata, data_hidden_out, h_rd_addr,
      input  w_addr, data_ir, data_iz, data_in, data_hr, data_hz, data_hn,
      input  data_hidden_in, busy, done, h_rd_data
   );

   modport slave (
      input  start, clear_h, x_wr_en, x_wr_addr, x_wr_data,
      input  w_ih_rdata, w_hh_rdata, data_hidden_out, h_rd_addr,
      output w_addr, data_ir, data_iz, data_in, data_hr, data_hz, data_hn,
      output data_hidden_in, busy, done, h_rd_data
   );
endinterface

// File: rtl/gru_gate_feeder.sv
// Sequences one GRU timestep: per hidden unit, MACs the six gate pre-activations, drives the cell, captures h.
// Define GRU_FEEDER_SAT_EN to saturate gate results instead of wrapping them.
module gru_gate_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int QUAN       = 24,
   parameter int HID        = 8,
   parameter int IN_DIM     = 4,
   parameter int CELL_LAT   = 20
) (
   input logic              clk,
   input logic              rst,
   gru_gate_feeder_if.slave bus
);
   localparam int AW    = $clog2(HID);
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int ACC_W = PW + AW;
   localparam int HW    = $clog2(CELL_LAT + 1);
   localparam logic [AW-1:0] LAST = AW'(HID - 1);

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_FLUSH, S_HOLD, S_CAPTURE, S_COMMIT} state_t;

   state_t                                state;
   logic [AW-1:0]                         unit_p0;
   logic [AW-1:0]                         col_p0;
   logic [HW-1:0]                         hold_cnt;
   logic                                  busy_q;
   logic                                  done_q;
   logic [AW-1:0]                         col_p1;
   logic                                  vld_p1;
   logic [HID-1:0][DATA_WIDTH-1:0]        x_mem;
   logic [HID-1:0][DATA_WIDTH-1:0]        h_mem;
   logic [HID-1:0][DATA_WIDTH-1:0]        hn_mem;
   logic signed [ACC_W-1:0]               acc_ir, acc_iz, acc_in, acc_hr, acc_hz, acc_hn;
   logic signed [ACC_W-1:0]               nxt_ir, nxt_iz, nxt_in, nxt_hr, nxt_hz, nxt_hn;
   logic signed [DATA_WIDTH-1:0]          o_ir, o_iz, o_in, o_hr, o_hz, o_hn, o_hid;
   logic signed [DATA_WIDTH-1:0]          wi_r, wi_z, wi_n, wh_r, wh_z, wh_n;
   logic signed [DATA_WIDTH-1:0]          x_p1, h_p1;
   logic signed [PW-1:0]                  pi_r, pi_z, pi_n, ph_r, ph_z, ph_n;
   logic                                  use_x;

`ifdef GRU_FEEDER_SAT_EN
   localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] W_MIN = ~W_MAX;
`endif

   function automatic logic signed [DATA_WIDTH-1:0] fit_word(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> QUAN;
`ifdef GRU_FEEDER_SAT_EN
      if (sh > W_MAX) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      if (sh < W_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
      return DATA_WIDTH'(sh);
   endfunction

   assign wi_r = bus.w_ih_rdata[DATA_WIDTH-1:0];
   assign wi_z = bus.w_ih_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign wi_n = bus.w_ih_rdata[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign wh_r = bus.w_hh_rdata[DATA_WIDTH-1:0];
   assign wh_z = bus.w_hh_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign wh_n = bus.w_hh_rdata[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign x_p1 = x_mem[col_p1];
   assign h_p1 = h_mem[col_p1];
   assign use_x = vld_p1 && (32'(col_p1) < IN_DIM);

   assign pi_r = wi_r * x_p1;
   assign pi_z = wi_z * x_p1;
   assign pi_n = wi_n * x_p1;
   assign ph_r = wh_r * h_p1;
   assign ph_z = wh_z * h_p1;
   assign ph_n = wh_n * h_p1;

   always_comb begin
      nxt_ir = acc_ir;
      nxt_iz = acc_iz;
      nxt_in = acc_in;
      nxt_hr = acc_hr;
      nxt_hz = acc_hz;
      nxt_hn = acc_hn;
      if (vld_p1) begin
         nxt_hr = acc_hr + ACC_W'(ph_r);
         nxt_hz = acc_hz + ACC_W'(ph_z);
         nxt_hn = acc_hn + ACC_W'(ph_n);
      end
      if (use_x) begin
         nxt_ir = acc_ir + ACC_W'(pi_r);
         nxt_iz = acc_iz + ACC_W'(pi_z);
         nxt_in = acc_in + ACC_W'(pi_n);
      end
   end

   // p0 -> p1: weight words return one cycle after the address, so the column index rides along
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         col_p1 <= col_p0;
         vld_p1 <= (state == S_MAC);
      end
   end

   // IDLE and CAPTURE are the only states that precede MAC, so zeroing there clears at MAC entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst || state == S_IDLE || state == S_CAPTURE) begin
         acc_ir <= '0;
         acc_iz <= '0;
         acc_in <= '0;
         acc_hr <= '0;
         acc_hz <= '0;
         acc_hn <= '0;
      end else begin
         acc_ir <= nxt_ir;
         acc_iz <= nxt_iz;
         acc_in <= nxt_in;
         acc_hr <= nxt_hr;
         acc_hz <= nxt_hz;
         acc_hn <= nxt_hn;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         unit_p0  <= '0;
         col_p0   <= '0;
         hold_cnt <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         x_mem    <= '0;
         h_mem    <= '0;
         hn_mem   <= '0;
         o_ir     <= '0;
         o_iz     <= '0;
         o_in     <= '0;
         o_hr     <= '0;
         o_hz     <= '0;
         o_hn     <= '0;
         o_hid    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.x_wr_en) x_mem[bus.x_wr_addr] <= bus.x_wr_data;
               if (bus.clear_h) begin
                  h_mem <= '0;
               end else if (bus.start) begin
                  state   <= S_MAC;
                  busy_q  <= 1'b1;
                  unit_p0 <= '0;
                  col_p0  <= '0;
               end
            end
            S_MAC: begin
               if (col_p0 == LAST) state <= S_FLUSH;
               else col_p0 <= col_p0 + AW'(1);
            end
            S_FLUSH: begin
               // the last column's product lands on this edge, so use the next-state sums
               state    <= S_HOLD;
               hold_cnt <= '0;
               o_ir     <= fit_word(nxt_ir);
               o_iz     <= fit_word(nxt_iz);
               o_in     <= fit_word(nxt_in);
               o_hr     <= fit_word(nxt_hr);
               o_hz     <= fit_word(nxt_hz);
               o_hn     <= fit_word(nxt_hn);
               o_hid    <= h_mem[unit_p0];
            end
            S_HOLD: begin
               if (hold_cnt == HW'(CELL_LAT - 1)) state <= S_CAPTURE;
               else hold_cnt <= hold_cnt + HW'(1);
            end
            S_CAPTURE: begin
               hn_mem[unit_p0] <= bus.data_hidden_out;
               if (unit_p0 == LAST) begin
                  state <= S_COMMIT;
               end else begin
                  state   <= S_MAC;
                  unit_p0 <= unit_p0 + AW'(1);
                  col_p0  <= '0;
               end
            end
            S_COMMIT: begin
               h_mem  <= hn_mem;
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.w_addr         = {unit_p0, col_p0};
   assign bus.data_ir        = o_ir;
   assign bus.data_iz        = o_iz;
   assign bus.data_in        = o_in;
   assign bus.data_hr        = o_hr;
   assign bus.data_hz        = o_hz;
   assign bus.data_hn        = o_hn;
   assign bus.data_hidden_in = o_hid;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.h_rd_data      = h_mem[bus.h_rd_addr];
endmodule

// File: tb/tb_gru_gate_feeder.sv
// Bench for gru_gate_feeder: weight memory model, stub GRU cell, and a sum-of-products reference model.
module tb_gru_gate_feeder;
   localparam int DW       = 32;
   localparam int QUAN     = 24;
   localparam int HID      = 8;
   localparam int IN_DIM   = 4;
   localparam int CELL_LAT = 20;
   localparam int AW       = $clog2(HID);
   localparam int U        = HID + CELL_LAT + 2;
   localparam int L        = HID * U + 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   bit   cell_mix = 1'b0;

   always #5 clk = ~clk;

   gru_gate_feeder_if #(.DATA_WIDTH(DW), .HID(HID)) bus ();

   gru_gate_feeder #(
      .DATA_WIDTH(DW), .QUAN(QUAN), .HID(HID), .IN_DIM(IN_DIM), .CELL_LAT(CELL_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [3*DW-1:0] mem_ih [HID*HID];
   logic [3*DW-1:0] mem_hh [HID*HID];
   logic [DW-1:0]   x_m [HID];
   logic [DW-1:0]   h_m [HID];
   logic [DW-1:0]   exp_o [HID][7];

   always @(posedge clk) begin
      bus.w_ih_rdata <= mem_ih[bus.w_addr];
      bus.w_hh_rdata <= mem_hh[bus.w_addr];
   end

   assign bus.data_hidden_out = bus.data_hidden_in + 32'h0100_0000 +
                                (cell_mix ? (bus.data_ir ^ bus.data_hn) : 32'h0);

   function automatic logic [DW-1:0] fit(input logic signed [127:0] s);
      logic signed [127:0] t;
      t = s >>> QUAN;
`ifdef GRU_FEEDER_SAT_EN
      if (t > 128'sd2147483647) return 32'h7FFF_FFFF;
      if (t < -128'sd2147483648) return 32'h8000_0000;
`endif
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] rnd(input bit big);
      if (big) return $urandom();
      return DW'($urandom_range(0, 32'h0400_0000) - 32'h0200_0000);
   endfunction

   task automatic predict();
      for (int j = 0; j < HID; j++) begin
         for (int g = 0; g < 3; g++) begin
            logic signed [127:0] si, sh, a, b;
            si = 0;
            sh = 0;
            for (int k = 0; k < HID; k++) begin
               a = $signed(mem_hh[j*HID+k][g*DW +: DW]);
               b = $signed(h_m[k]);
               sh += a * b;
               if (k < IN_DIM) begin
                  a = $signed(mem_ih[j*HID+k][g*DW +: DW]);
                  b = $signed(x_m[k]);
                  si += a * b;
               end
            end
            exp_o[j][g]   = fit(si);
            exp_o[j][3+g] = fit(sh);
         end
         exp_o[j][6] = h_m[j];
      end
   endtask

   task automatic load_x(input int mode, input logic [DW-1:0] val);
      for (int k = 0; k < HID; k++) begin
         @(posedge clk); #1;
         x_m[k] = (mode == 0) ? val : rnd(mode == 2);
         bus.x_wr_en   = 1'b1;
         bus.x_wr_addr = AW'(k);
         bus.x_wr_data = x_m[k];
      end
      @(posedge clk); #1;
      bus.x_wr_en = 1'b0;
   endtask

   task automatic rand_weights(input bit big);
      for (int i = 0; i < HID*HID; i++) begin
         mem_ih[i] = {rnd(big), rnd(big), rnd(big)};
         mem_hh[i] = {rnd(big), rnd(big), rnd(big)};
      end
   endtask

   task automatic check_h(input string tag);
      for (int j = 0; j < HID; j++) begin
         bus.h_rd_addr = AW'(j);
         #1;
         total++;
         if (bus.h_rd_data !== h_m[j]) begin
            bad++;
            $display("FAIL %s h[%0d]: got %h want %h", tag, j, bus.h_rd_data, h_m[j]);
         end
      end
   endtask

   task automatic run_step(input bit disturb);
      logic [DW-1:0]   act [7];
      logic [2*AW-1:0] ea;
      int j, ph;
      predict();
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= L + 3; c++) begin
         j  = (c - 1) / U;
         ph = (c - 1) % U;
         if (c <= HID*U && ph < HID) begin
            ea = (2*AW)'(j*HID + ph);
            total++;
            if (bus.w_addr !== ea) begin
               bad++;
               $display("FAIL w_addr cyc %0d: got %h want %h", c, bus.w_addr, ea);
            end
         end
         if (c <= HID*U && (ph == HID + 1 || ph == U - 1)) begin
            act = '{bus.data_ir, bus.data_iz, bus.data_in, bus.data_hr,
                    bus.data_hz, bus.data_hn, bus.data_hidden_in};
            for (int i = 0; i < 7; i++) begin
               total++;
               if (act[i] !== exp_o[j][i]) begin
                  bad++;
                  $display("FAIL gate unit %0d out %0d cyc %0d: got %h want %h", j, i, c, act[i], exp_o[j][i]);
               end
            end
         end
         total++;
         if (bus.busy !== (c <= HID*U + 1)) begin
            bad++;
            $display("FAIL busy cyc %0d: got %b", c, bus.busy);
         end
         total++;
         if (bus.done !== (c == L)) begin
            bad++;
            $display("FAIL done cyc %0d: got %b want %b", c, bus.done, (c == L));
         end
         if (disturb) begin
            if (c == 5 || c == HID*U + 1) begin
               bus.start     = 1'b1;
               bus.clear_h   = 1'b1;
               bus.x_wr_en   = 1'b1;
               bus.x_wr_addr = '0;
               bus.x_wr_data = ~x_m[0];
            end else begin
               bus.start   = 1'b0;
               bus.clear_h = 1'b0;
               bus.x_wr_en = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      for (int u = 0; u < HID; u++)
         h_m[u] = exp_o[u][6] + 32'h0100_0000 + (cell_mix ? (exp_o[u][0] ^ exp_o[u][5]) : 32'h0);
      check_h("step");
   endtask

   task automatic test_reset();
      logic [DW-1:0] act [7];
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      act = '{bus.data_ir, bus.data_iz, bus.data_in, bus.data_hr,
              bus.data_hz, bus.data_hn, bus.data_hidden_in};
      for (int i = 0; i < 7; i++) begin
         total++;
         if (act[i] !== '0) begin
            bad++;
            $display("FAIL reset out %0d: got %h want 0", i, act[i]);
         end
      end
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_addr !== '0) begin
         bad++;
         $display("FAIL reset ctrl: busy %b done %b w_addr %h want 0", bus.busy, bus.done, bus.w_addr);
      end
      rst = 1'b0;
      for (int j = 0; j < HID; j++) begin
         h_m[j] = '0;
         x_m[j] = '0;
      end
      check_h("reset");
   endtask

   task automatic test_gate_sums();
      for (int i = 0; i < HID*HID; i++) begin
         mem_ih[i] = {32'h0, 32'h0, 32'h0080_0000};
         mem_hh[i] = '0;
      end
      cell_mix = 1'b0;
      load_x(0, 32'h0100_0000);
      run_step(1'b0);
      total++;
      if (bus.data_ir !== 32'h0200_0000 || bus.data_hr !== 32'h0) begin
         bad++;
         $display("FAIL gate_sums: ir %h hr %h want 02000000 00000000", bus.data_ir, bus.data_hr);
      end
   endtask

   task automatic test_two_timesteps();
      bus.h_rd_addr = '0;
      #1;
      total++;
      if (bus.h_rd_data !== 32'h0100_0000) begin
         bad++;
         $display("FAIL step1 h[0]: got %h want 01000000", bus.h_rd_data);
      end
      run_step(1'b0);
      for (int j = 0; j < HID; j++) begin
         bus.h_rd_addr = AW'(j);
         #1;
         total++;
         if (bus.h_rd_data !== 32'h0200_0000) begin
            bad++;
            $display("FAIL step2 h[%0d]: got %h want 02000000", j, bus.h_rd_data);
         end
      end
   endtask

   task automatic test_clear_start();
      @(posedge clk); #1;
      bus.clear_h = 1'b1;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.clear_h = 1'b0;
      bus.start   = 1'b0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL clear_start cyc %0d: busy %b done %b want 0 0", c, bus.busy, bus.done);
         end
         @(posedge clk); #1;
      end
      for (int j = 0; j < HID; j++) h_m[j] = '0;
      check_h("clear_start");
   endtask

   task automatic test_saturation();
      logic [DW-1:0] want;
      for (int i = 0; i < HID*HID; i++) begin
         mem_ih[i] = {32'h0, 32'h0, 32'h7FFF_FFFF};
         mem_hh[i] = {rnd(1'b0), rnd(1'b0), rnd(1'b0)};
      end
      load_x(0, 32'h7FFF_FFFF);
      run_step(1'b0);
`ifdef GRU_FEEDER_SAT_EN
      want = 32'h7FFF_FFFF;
`else
      want = 32'hFFFF_FC00;
`endif
      total++;
      if (bus.data_ir !== want) begin
         bad++;
         $display("FAIL saturation ir: got %h want %h", bus.data_ir, want);
      end
   endtask

   task automatic test_busy_ignore();
      rand_weights(1'b0);
      load_x(1, '0);
      cell_mix = 1'b1;
      run_step(1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 3; n++) begin
         rand_weights(n == 2);
         load_x((n == 2) ? 2 : 1, '0);
         run_step(1'b0);
      end
   endtask

   task automatic test_mid_reset();
      logic [DW-1:0] act [7];
      rand_weights(1'b0);
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3*U + HID + 4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      act = '{bus.data_ir, bus.data_iz, bus.data_in, bus.data_hr,
              bus.data_hz, bus.data_hn, bus.data_hidden_in};
      for (int i = 0; i < 7; i++) begin
         total++;
         if (act[i] !== '0) begin
            bad++;
            $display("FAIL mid_reset out %0d: got %h want 0", i, act[i]);
         end
      end
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_addr !== '0) begin
         bad++;
         $display("FAIL mid_reset ctrl: busy %b done %b w_addr %h want 0", bus.busy, bus.done, bus.w_addr);
      end
      #1;
      rst = 1'b0;
      for (int j = 0; j < HID; j++) begin
         h_m[j] = '0;
         x_m[j] = '0;
      end
      check_h("mid_reset");
      for (int c = 0; c < 2*U; c++) begin
         @(posedge clk); #1;
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset idle cyc %0d: done %b busy %b want 0 0", c, bus.done, bus.busy);
         end
      end
      run_step(1'b0);
      load_x(1, '0);
      run_step(1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.clear_h   = 1'b0;
      bus.x_wr_en   = 1'b0;
      bus.x_wr_addr = '0;
      bus.x_wr_data = '0;
      bus.h_rd_addr = '0;
      for (int i = 0; i < HID*HID; i++) begin
         mem_ih[i] = '0;
         mem_hh[i] = '0;
      end
      test_reset();
      test_gate_sums();
      test_two_timesteps();
      test_clear_start();
      test_saturation();
      test_busy_ignore();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gru_gate_feeder.md
GRU_GATE_FEEDER -- requirements
Module: gru_gate_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed Q(DATA_WIDTH-QUAN).QUAN word width.
REQ-002 SHALL have parameter QUAN, default 24: fractional bits of all data words.
REQ-003 SHALL have parameter HID, default 8: hidden units, power of two, at least 2.
REQ-004 SHALL have parameter IN_DIM, default 4: input vector length, 1 to HID.
REQ-005 SHALL have parameter CELL_LAT, default 20: downstream GRU cell latency in cycles, at least 1.
REQ-006 SHALL have ports: clk in 1 (single clock, rising edge); rst in 1 (asynchronous, active-high).
REQ-007 SHALL have ports: start in 1 (begin one timestep); clear_h in 1 (zero hidden state).
REQ-008 SHALL have ports: x_wr_en in 1, x_wr_addr in clog2(HID), x_wr_data in DATA_WIDTH (input vector load).
REQ-009 SHALL have ports: w_addr out 2*clog2(HID), {unit j, column k}; w_ih_rdata in 3*DATA_WIDTH and w_hh_rdata in 3*DATA_WIDTH, packed {n,z,r}, valid one cycle after w_addr.
REQ-010 SHALL have ports: data_ir, data_iz, data_in, data_hr, data_hz, data_hn, data_hidden_in, each out DATA_WIDTH (drive GRU cell).
REQ-011 SHALL have port data_hidden_out in DATA_WIDTH (GRU cell result).
REQ-012 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); h_rd_addr in clog2(HID); h_rd_data out DATA_WIDTH (combinational read of committed h).

Function
REQ-013 SHALL implement FSM IDLE -> MAC -> FLUSH -> HOLD -> CAPTURE -> (MAC for next unit | COMMIT) -> IDLE.
REQ-014 SHALL leave IDLE only on start=1 sampled in IDLE; start SHALL be ignored elsewhere.
REQ-015 MAC SHALL last HID cycles per unit j, issuing w_addr={j,k} for k=0..HID-1; FLUSH SHALL absorb the one-cycle read latency.
REQ-016 Accumulation per returned column k SHALL be: acc_h{r,z,n} += w_hh*h[k]; acc_i{r,z,n} += w_ih*x[k] only when k<IN_DIM.
REQ-017 Products SHALL be full 2*DATA_WIDTH signed, accumulated in 2*DATA_WIDTH+clog2(HID) bits, result = acc arithmetic-shifted right by QUAN, then truncated to DATA_WIDTH (see REQ-027).
REQ-018 Accumulators SHALL be cleared at entry to MAC for each unit.
REQ-019 The seven data_* outputs SHALL update on the edge entering HOLD; data_hidden_in = h[j]; all SHALL stay constant through HOLD and CAPTURE.
REQ-020 HOLD SHALL last CELL_LAT cycles; CAPTURE SHALL sample data_hidden_out into h_next[j].
REQ-021 h[] SHALL not change during a timestep; COMMIT SHALL copy h_next[] to h[] in one cycle.
REQ-022 done SHALL pulse the cycle after COMMIT; start-to-done latency SHALL be HID*(HID+CELL_LAT+2)+2 cycles.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 x_wr_en and clear_h SHALL act only in IDLE and SHALL be ignored while busy; clear_h has priority over start in the same cycle.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE and clear accumulators, h[], h_next[], x[], w_addr, all data_* outputs, busy and done to 0.
REQ-026 Reset mid-timestep SHALL abandon the timestep with no COMMIT and no done pulse.

Configuration
REQ-027 With GRU_FEEDER_SAT_EN defined, shifted results out of DATA_WIDTH signed range SHALL saturate to 0x7FFF_FFFF / 0x8000_0000; without it they SHALL wrap (keep low DATA_WIDTH bits).

Verification
REQ-028 Scenario: x=all 0x0100_0000, w_ih r-column weights 0x0080_0000, h=0, start -> every unit shows data_ir=0x0200_0000, data_hr=0.
REQ-029 Scenario: stub cell returns data_hidden_in+0x0100_0000; two timesteps -> h[j] reads 0x0100_0000 then 0x0200_0000; done exactly at cycle HID*(HID+CELL_LAT+2)+2 after start.
REQ-030 Scenario: x[k]=w_ih[k]=0x7FFF_FFFF, IN_DIM=4 -> data_ir=0x7FFF_FFFF with GRU_FEEDER_SAT_EN; low-32 wrapped value without.
REQ-031 Scenario: start, x_wr_en, clear_h pulsed while busy -> no effect on outputs, x[] or h[]; one done only.
REQ-032 Scenario: rst asserted in HOLD of unit 3 -> all outputs 0 same cycle, h[] all 0, no done; subsequent start runs a normal timestep.
REQ-033 Scenario: clear_h and start same IDLE cycle -> h cleared, FSM stays IDLE, busy=0.
